ad9637_spi_cfg_ctrl: RTL and testbench



---
 rtl/ad9637_spi_cfg_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ad9637_spi_cfg_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9637_spi_cfg_ctrl.sv
// AD9637 3-wire SPI configuration sequencer: one single-byte register read or
// write per command, optionally followed by the 0xFF <- 0x01 device-update write.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high once out of reset
// SETUP | CSB low, first bit on SDIO, CLK_DIV cycles before the first SCLK
// SHIFT | 24 SCLK periods (low phase then high phase, CLK_DIV cycles each)
// HOLD  | SCLK low, CSB still low, CLK_DIV cycles
// GAP   | CSB high for 2*CLK_DIV cycles; chains into the commit frame if pending
// RESP  | one-cycle rsp_valid
module ad9637_spi_cfg_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic        cmd_commit,
    input  logic [12:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic        spi_csb,
    output logic        spi_sclk,
    output logic        spi_sdio_o,
    output logic        spi_sdio_oe,
    input  logic        spi_sdio_i
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4,
        RESP  = 3'd5
    } state_t;

    localparam logic [8:0]  DIV_LD       = 9'(CLK_DIV - 1);
    localparam logic [8:0]  GAP_LD       = 9'(2 * CLK_DIV - 1);
    localparam logic [23:0] COMMIT_FRAME = {1'b0, 2'b00, 13'h00FF, 8'h01};

    state_t      state;
    state_t      state_next;
    logic [8:0]  div_cnt;
    logic        div_tc;
    logic        phase_high;
    logic [4:0]  bit_cnt;
    logic        last_bit;
    logic [23:0] frame;
    logic        is_read;
    logic        commit_pend;
    logic [7:0]  rx_data;
    logic        run;
    logic        accept;

    assign div_tc   = (div_cnt == 9'd0);
    assign last_bit = (bit_cnt == 5'd23);
    assign accept   = cmd_valid && cmd_ready;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        busy        = 1'b1;
        spi_csb     = 1'b1;
        spi_sclk    = 1'b0;
        spi_sdio_o  = 1'b0;
        spi_sdio_oe = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = run;
                if (cmd_valid && run) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                spi_csb     = 1'b0;
                spi_sdio_oe = 1'b1;
                spi_sdio_o  = frame[23];
                if (div_tc) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                spi_csb     = 1'b0;
                spi_sclk    = phase_high;
                spi_sdio_o  = frame[23];
                // Reads hand SDIO to the ADC once the 16 instruction bits are out.
                spi_sdio_oe = !(is_read && (bit_cnt >= 5'd16));
                if (div_tc && phase_high && last_bit) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                spi_csb     = 1'b0;
                spi_sdio_o  = frame[23];
                spi_sdio_oe = !is_read;
                if (div_tc) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (div_tc) begin
                    state_next = commit_pend ? SETUP : RESP;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            run         <= 1'b0;
            div_cnt     <= 9'd0;
            phase_high  <= 1'b0;
            bit_cnt     <= 5'd0;
            frame       <= 24'd0;
            is_read     <= 1'b0;
            commit_pend <= 1'b0;
            rx_data     <= 8'd0;
            rsp_rdata   <= 8'd0;
        end else begin
            run <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        frame       <= {cmd_rw, 2'b00, cmd_addr, cmd_wdata};
                        is_read     <= cmd_rw;
                        commit_pend <= cmd_commit && !cmd_rw;
                        div_cnt     <= DIV_LD;
                        bit_cnt     <= 5'd0;
                        phase_high  <= 1'b0;
                    end
                end
                SETUP: begin
                    div_cnt <= div_tc ? DIV_LD : div_cnt - 9'd1;
                end
                SHIFT: begin
                    if (div_tc) begin
                        div_cnt    <= DIV_LD;
                        phase_high <= !phase_high;
                        // End of a high phase is the SCLK fall: present the next bit.
                        if (phase_high) begin
                            frame   <= {frame[22:0], 1'b0};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt - 9'd1;
                    end
                    if (phase_high && (div_cnt == DIV_LD) && is_read && (bit_cnt >= 5'd16)) begin
                        rx_data <= {rx_data[6:0], spi_sdio_i};
                    end
                end
                HOLD: begin
                    div_cnt <= div_tc ? GAP_LD : div_cnt - 9'd1;
                end
                GAP: begin
                    if (div_tc) begin
                        if (commit_pend) begin
                            frame       <= COMMIT_FRAME;
                            commit_pend <= 1'b0;
                            div_cnt     <= DIV_LD;
                            bit_cnt     <= 5'd0;
                            phase_high  <= 1'b0;
                        end else begin
                            rsp_rdata <= is_read ? rx_data : 8'h00;
                        end
                    end else begin
                        div_cnt <= div_cnt - 9'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad9637_spi_cfg_ctrl.sv
// Directed bench for ad9637_spi_cfg_ctrl: a CLK_DIV=4 instance (a) and a
// CLK_DIV=2 instance (b), observed through a selectable view.
module tb_ad9637_spi_cfg_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        cmd_valid_a = 1'b0;
    logic        cmd_valid_b = 1'b0;
    logic        cmd_rw = 1'b0;
    logic        cmd_commit = 1'b0;
    logic [12:0] cmd_addr = 13'd0;
    logic [7:0]  cmd_wdata = 8'd0;
    logic        sdio_i = 1'b0;
    logic        sel = 1'b0;

    logic       ready_a, rsp_a, busy_a, csb_a, sclk_a, sdo_a, oe_a;
    logic       ready_b, rsp_b, busy_b, csb_b, sclk_b, sdo_b, oe_b;
    logic [7:0] rdata_a, rdata_b;

    logic       o_ready, o_rsp, o_busy, o_csb, o_sclk, o_sdo, o_oe;
    logic [7:0] o_rdata;

    int vec_cnt = 0;
    int err_cnt = 0;

    int          t_wait, t_lat, t_pulses, t_gap, t_oe_drop, t_period;
    int          t_rises [2];
    logic [23:0] t_frame [2];
    logic [7:0]  t_rdata;
    logic        t_oe_fall, t_edge_bad, t_ready_bad;
    logic        a_csb, a_sclk, a_oe, a_rsp, a_busy, a_ready;

    always #5 ACLK = ~ACLK;

    ad9637_spi_cfg_ctrl #(.CLK_DIV(4)) dut_a (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid_a), .cmd_ready(ready_a), .cmd_rw(cmd_rw),
        .cmd_commit(cmd_commit), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_a), .rsp_rdata(rdata_a), .busy(busy_a),
        .spi_csb(csb_a), .spi_sclk(sclk_a), .spi_sdio_o(sdo_a),
        .spi_sdio_oe(oe_a), .spi_sdio_i(sdio_i)
    );

    ad9637_spi_cfg_ctrl #(.CLK_DIV(2)) dut_b (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid_b), .cmd_ready(ready_b), .cmd_rw(cmd_rw),
        .cmd_commit(cmd_commit), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_b), .rsp_rdata(rdata_b), .busy(busy_b),
        .spi_csb(csb_b), .spi_sclk(sclk_b), .spi_sdio_o(sdo_b),
        .spi_sdio_oe(oe_b), .spi_sdio_i(sdio_i)
    );

    assign o_ready = sel ? ready_b : ready_a;
    assign o_rsp   = sel ? rsp_b   : rsp_a;
    assign o_busy  = sel ? busy_b  : busy_a;
    assign o_csb   = sel ? csb_b   : csb_a;
    assign o_sclk  = sel ? sclk_b  : sclk_a;
    assign o_sdo   = sel ? sdo_b   : sdo_a;
    assign o_oe    = sel ? oe_b    : oe_a;
    assign o_rdata = sel ? rdata_b : rdata_a;

    // Drives one command from a negedge and watches the pins until rsp_valid.
    // abort_at > 0 pulls ARESETN after that many SCLK rises and snapshots the pins.
    task automatic do_txn(input logic rw, input logic commit, input logic [12:0] addr,
                          input logic [7:0] wdata, input logic [7:0] rd_byte,
                          input logic keep, input int abort_at);
        logic p_sclk, p_csb;
        int   gap_cur, rise1_n;
        cmd_rw = rw; cmd_commit = commit; cmd_addr = addr; cmd_wdata = wdata; sdio_i = 1'b0;
        if (sel) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
        t_wait = 0; t_lat = -1; t_pulses = 0; t_gap = -1; t_oe_drop = 99; t_period = -1;
        t_rises[0] = 0; t_rises[1] = 0; t_frame[0] = 24'd0; t_frame[1] = 24'd0;
        t_oe_fall = 1'b0; t_edge_bad = 1'b0; t_ready_bad = 1'b0; t_rdata = 8'hxx;
        rise1_n = -1; gap_cur = 0;
        while (!o_ready && t_wait < 50) begin
            @(negedge ACLK);
            t_wait++;
        end
        if (!o_ready) begin
            cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
            return;
        end
        p_sclk = o_sclk; p_csb = o_csb;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge ACLK);
            if (n == 1 && !keep) begin cmd_valid_a = 1'b0; cmd_valid_b = 1'b0; end
            if ((o_csb != p_csb) && (o_sclk || p_sclk)) t_edge_bad = 1'b1;
            if (!o_csb && p_csb) begin
                if (t_pulses > 0) t_gap = gap_cur;
                t_pulses++;
            end
            if (o_csb) gap_cur++; else gap_cur = 0;
            if (o_sclk && !p_sclk) begin
                if (t_pulses >= 1 && t_pulses <= 2) begin
                    t_rises[t_pulses-1]++;
                    t_frame[t_pulses-1] = {t_frame[t_pulses-1][22:0], o_sdo};
                end
                if (rise1_n < 0) rise1_n = n;
                else if (t_period < 0) t_period = n - rise1_n;
                if (abort_at > 0 && t_pulses == 1 && t_rises[0] == abort_at) begin
                    ARESETN = 1'b0;
                    #1;
                    a_csb = o_csb; a_sclk = o_sclk; a_oe = o_oe;
                    a_rsp = o_rsp; a_busy = o_busy; a_ready = o_ready;
                    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
                    return;
                end
            end
            if (!o_sclk && p_sclk && t_pulses == 1 && t_rises[0] >= 16 && t_rises[0] < 24)
                sdio_i = rd_byte[23 - t_rises[0]];
            if (!o_csb && !o_oe && t_oe_drop == 99) begin
                t_oe_drop = t_rises[0];
                t_oe_fall = p_sclk && !o_sclk;
            end
            if (o_ready) t_ready_bad = 1'b1;
            if (o_rsp) begin
                t_lat = n;
                t_rdata = o_rdata;
                break;
            end
            p_sclk = o_sclk; p_csb = o_csb;
        end
        if (t_lat < 0) begin cmd_valid_a = 1'b0; cmd_valid_b = 1'b0; end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge ACLK);
        vec_cnt++; if ({ready_a, rsp_a, busy_a} !== 3'b000) begin err_cnt++;
            $display("FAIL reset_ctl: ready/rsp/busy got %b want 000", {ready_a, rsp_a, busy_a}); end
        vec_cnt++; if ({csb_a, sclk_a, sdo_a, oe_a} !== 4'b1000) begin err_cnt++;
            $display("FAIL reset_pins: csb/sclk/sdo/oe got %b want 1000", {csb_a, sclk_a, sdo_a, oe_a}); end
        vec_cnt++; if (rdata_a !== 8'h00) begin err_cnt++;
            $display("FAIL reset_rdata: got %h want 00", rdata_a); end
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        vec_cnt++; if (ready_a !== 1'b1) begin err_cnt++;
            $display("FAIL ready_after_reset: got %b want 1", ready_a); end
    endtask

    task automatic test_write();
        @(negedge ACLK);
        do_txn(1'b0, 1'b0, 13'h014, 8'h41, 8'h00, 1'b0, 0);
        vec_cnt++; if (t_lat !== 209) begin err_cnt++; $display("FAIL wr_latency: got %0d want 209", t_lat); end
        vec_cnt++; if (t_frame[0] !== 24'h001441) begin err_cnt++; $display("FAIL wr_frame: got %h want 001441", t_frame[0]); end
        vec_cnt++; if (t_rises[0] !== 24) begin err_cnt++; $display("FAIL wr_rises: got %0d want 24", t_rises[0]); end
        vec_cnt++; if (t_pulses !== 1) begin err_cnt++; $display("FAIL wr_csb_pulses: got %0d want 1", t_pulses); end
        vec_cnt++; if (t_rdata !== 8'h00) begin err_cnt++; $display("FAIL wr_rdata: got %h want 00", t_rdata); end
        vec_cnt++; if (t_oe_drop !== 99) begin err_cnt++; $display("FAIL wr_oe_drop: oe fell after %0d rises, want none", t_oe_drop); end
        vec_cnt++; if (t_edge_bad !== 1'b0) begin err_cnt++; $display("FAIL wr_sclk_at_csb_edge: got %b want 0", t_edge_bad); end
        vec_cnt++; if (t_ready_bad !== 1'b0) begin err_cnt++; $display("FAIL wr_ready_while_busy: got %b want 0", t_ready_bad); end
    endtask

    task automatic test_read();
        @(negedge ACLK);
        do_txn(1'b1, 1'b0, 13'h001, 8'h00, 8'h93, 1'b0, 0);
        vec_cnt++; if (t_lat !== 209) begin err_cnt++; $display("FAIL rd_latency: got %0d want 209", t_lat); end
        vec_cnt++; if (t_frame[0][23:8] !== 16'h8001) begin err_cnt++; $display("FAIL rd_instr: got %h want 8001", t_frame[0][23:8]); end
        vec_cnt++; if (t_oe_drop !== 16) begin err_cnt++; $display("FAIL rd_oe_drop: got %0d rises want 16", t_oe_drop); end
        vec_cnt++; if (t_oe_fall !== 1'b1) begin err_cnt++; $display("FAIL rd_oe_on_fall: got %b want 1", t_oe_fall); end
        vec_cnt++; if (t_rdata !== 8'h93) begin err_cnt++; $display("FAIL rd_data: got %h want 93", t_rdata); end
        vec_cnt++; if (t_rises[0] !== 24) begin err_cnt++; $display("FAIL rd_rises: got %0d want 24", t_rises[0]); end
    endtask

    task automatic test_read_commit_ignored();
        @(negedge ACLK);
        do_txn(1'b1, 1'b1, 13'h002, 8'h00, 8'h5A, 1'b0, 0);
        vec_cnt++; if (t_pulses !== 1) begin err_cnt++; $display("FAIL rdc_pulses: got %0d want 1", t_pulses); end
        vec_cnt++; if (t_lat !== 209) begin err_cnt++; $display("FAIL rdc_latency: got %0d want 209", t_lat); end
        vec_cnt++; if (t_rdata !== 8'h5A) begin err_cnt++; $display("FAIL rdc_data: got %h want 5a", t_rdata); end
    endtask

    task automatic test_commit();
        @(negedge ACLK);
        do_txn(1'b0, 1'b1, 13'h008, 8'h03, 8'h00, 1'b0, 0);
        vec_cnt++; if (t_lat !== 417) begin err_cnt++; $display("FAIL cm_latency: got %0d want 417", t_lat); end
        vec_cnt++; if (t_pulses !== 2) begin err_cnt++; $display("FAIL cm_pulses: got %0d want 2", t_pulses); end
        vec_cnt++; if (t_frame[0] !== 24'h000803) begin err_cnt++; $display("FAIL cm_frame0: got %h want 000803", t_frame[0]); end
        vec_cnt++; if (t_frame[1] !== 24'h00FF01) begin err_cnt++; $display("FAIL cm_frame1: got %h want 00ff01", t_frame[1]); end
        vec_cnt++; if (t_gap !== 8) begin err_cnt++; $display("FAIL cm_gap: got %0d want 8", t_gap); end
        vec_cnt++; if (t_rises[1] !== 24) begin err_cnt++; $display("FAIL cm_rises1: got %0d want 24", t_rises[1]); end
        vec_cnt++; if (t_rdata !== 8'h00) begin err_cnt++; $display("FAIL cm_rdata: got %h want 00", t_rdata); end
        vec_cnt++; if (t_edge_bad !== 1'b0) begin err_cnt++; $display("FAIL cm_sclk_at_csb_edge: got %b want 0", t_edge_bad); end
    endtask

    task automatic test_back_to_back();
        @(negedge ACLK);
        do_txn(1'b0, 1'b0, 13'h021, 8'h7E, 8'h00, 1'b1, 0);
        vec_cnt++; if (t_lat !== 209) begin err_cnt++; $display("FAIL b2b_lat1: got %0d want 209", t_lat); end
        vec_cnt++; if (t_ready_bad !== 1'b0) begin err_cnt++; $display("FAIL b2b_ready1: got %b want 0", t_ready_bad); end
        do_txn(1'b0, 1'b0, 13'h1A5, 8'h3C, 8'h00, 1'b0, 0);
        vec_cnt++; if (t_wait !== 1) begin err_cnt++; $display("FAIL b2b_accept_gap: got %0d want 1", t_wait); end
        vec_cnt++; if (t_frame[0] !== 24'h01A53C) begin err_cnt++; $display("FAIL b2b_frame2: got %h want 01a53c", t_frame[0]); end
        vec_cnt++; if (t_lat !== 209) begin err_cnt++; $display("FAIL b2b_lat2: got %0d want 209", t_lat); end
        vec_cnt++; if (t_ready_bad !== 1'b0) begin err_cnt++; $display("FAIL b2b_ready2: got %b want 0", t_ready_bad); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge ACLK);
        do_txn(1'b0, 1'b0, 13'h055, 8'hAA, 8'h00, 1'b0, 10);
        vec_cnt++; if (t_rises[0] !== 10) begin err_cnt++; $display("FAIL mid_abort_point: got %0d rises want 10", t_rises[0]); end
        vec_cnt++; if ({a_csb, a_sclk, a_oe} !== 3'b100) begin err_cnt++;
            $display("FAIL mid_pins: csb/sclk/oe got %b want 100", {a_csb, a_sclk, a_oe}); end
        vec_cnt++; if ({a_rsp, a_busy, a_ready} !== 3'b000) begin err_cnt++;
            $display("FAIL mid_ctl: rsp/busy/ready got %b want 000", {a_rsp, a_busy, a_ready}); end
        seen = 1'b0;
        repeat (3) begin @(negedge ACLK); if (o_rsp) seen = 1'b1; end
        ARESETN = 1'b1;
        repeat (3) begin @(negedge ACLK); if (o_rsp) seen = 1'b1; end
        vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL mid_no_rsp: got %b want 0", seen); end
        do_txn(1'b0, 1'b0, 13'h0AB, 8'hC5, 8'h00, 1'b0, 0);
        vec_cnt++; if (t_lat !== 209) begin err_cnt++; $display("FAIL mid_after_lat: got %0d want 209", t_lat); end
        vec_cnt++; if (t_frame[0] !== 24'h00ABC5) begin err_cnt++; $display("FAIL mid_after_frame: got %h want 00abc5", t_frame[0]); end
    endtask

    task automatic test_clk_div2();
        @(negedge ACLK);
        sel = 1'b1;
        do_txn(1'b0, 1'b0, 13'h0FF, 8'h01, 8'h00, 1'b0, 0);
        vec_cnt++; if (t_lat !== 105) begin err_cnt++; $display("FAIL div2_latency: got %0d want 105", t_lat); end
        vec_cnt++; if (t_period !== 4) begin err_cnt++; $display("FAIL div2_period: got %0d want 4", t_period); end
        vec_cnt++; if (t_frame[0] !== 24'h00FF01) begin err_cnt++; $display("FAIL div2_frame: got %h want 00ff01", t_frame[0]); end
        vec_cnt++; if (t_rises[0] !== 24) begin err_cnt++; $display("FAIL div2_rises: got %0d want 24", t_rises[0]); end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_commit_ignored();
        test_commit();
        test_back_to_back();
        test_reset_mid();
        test_clk_div2();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
